// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the MEM-stage load/store unit and the data memory.
// The LSU is the master: it raises a request and waits for the acknowledge.
interface mem_lsu_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM stage of the five-stage pipeline. Non-memory ops pass straight through;
// loads and stores run a req/ack transaction on the data bus and hold the
// front of the pipeline with stallreq until the transaction has completed.
module mem_lsu (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ex_wd,
  input  logic             ex_wreg,
  input  logic [31:0]      ex_wdata,
  input  logic [31:0]      ex_hi,
  input  logic [31:0]      ex_lo,
  input  logic             ex_whilo,
  input  logic [7:0]       ex_aluop,
  input  logic [31:0]      ex_mem_addr,
  input  logic [31:0]      ex_reg2,
  output logic [4:0]       mem_wd,
  output logic             mem_wreg,
  output logic [31:0]      mem_wdata,
  output logic [31:0]      mem_hi,
  output logic [31:0]      mem_lo,
  output logic             mem_whilo,
  output logic             stallreq,
  output logic             addr_err,
  mem_lsu_if.master        dbus
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic        isLoad, isStore, isMem, misaligned;
  logic        isByte, isHalf;
  logic [3:0]  selBus;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic [1:0]  lane;

  assign lane = ex_mem_addr[1:0];

  // Decode the opcode into access size, direction, alignment, lane and store data.
  always_comb begin
    isLoad     = 1'b0;
    isStore    = 1'b0;
    isByte     = 1'b0;
    isHalf     = 1'b0;
    misaligned = 1'b0;
    selBus     = 4'b1111;
    storeData  = ex_reg2;
    case (ex_aluop)
      OP_LB, OP_LBU: begin isLoad  = 1'b1; isByte = 1'b1; end
      OP_LH, OP_LHU: begin isLoad  = 1'b1; isHalf = 1'b1; end
      OP_LW:         begin isLoad  = 1'b1; end
      OP_SB:         begin isStore = 1'b1; isByte = 1'b1; end
      OP_SH:         begin isStore = 1'b1; isHalf = 1'b1; end
      OP_SW:         begin isStore = 1'b1; end
      default:       ;
    endcase
    if (isByte) begin
      selBus    = 4'b1000 >> lane;
      storeData = {4{ex_reg2[7:0]}};
    end else if (isHalf) begin
      selBus     = {~lane[1], ~lane[1], lane[1], lane[1]};
      storeData  = {2{ex_reg2[15:0]}};
      misaligned = lane[0];
    end else begin
      misaligned = (lane != 2'b00);
    end
  end

  assign isMem = isLoad | isStore;

  // Extract and extend the addressed lane of the captured big-endian word.
  always_comb begin
    loadData = rdata_q;
    case (ex_aluop)
      OP_LB, OP_LBU: begin
        case (lane)
          2'b00:   loadData = {24'h0, rdata_q[31:24]};
          2'b01:   loadData = {24'h0, rdata_q[23:16]};
          2'b10:   loadData = {24'h0, rdata_q[15:8]};
          default: loadData = {24'h0, rdata_q[7:0]};
        endcase
        if (ex_aluop == OP_LB) loadData[31:8] = {24{loadData[7]}};
      end
      OP_LH, OP_LHU: begin
        loadData = lane[1] ? {16'h0, rdata_q[15:0]} : {16'h0, rdata_q[31:16]};
        if (ex_aluop == OP_LH) loadData[31:16] = {16{loadData[15]}};
      end
      default: ;
    endcase
  end

  // Next-state and output logic; rst forces every output low regardless of state.
  always_comb begin
    state_d         = state_q;
    rdata_d         = rdata_q;
    mem_wd          = ex_wd;
    mem_wreg        = ex_wreg;
    mem_wdata       = ex_wdata;
    mem_hi          = ex_hi;
    mem_lo          = ex_lo;
    mem_whilo       = ex_whilo;
    stallreq        = 1'b0;
    addr_err        = 1'b0;
    dbus.dbus_req   = 1'b0;
    dbus.dbus_we    = 1'b0;
    dbus.dbus_addr  = 32'h0;
    dbus.dbus_sel   = 4'b0000;
    dbus.dbus_wdata = 32'h0;
    case (state_q)
      IDLE, WAIT: begin
        if (isMem && !misaligned) begin
          dbus.dbus_req   = 1'b1;
          dbus.dbus_we    = isStore;
          dbus.dbus_addr  = {ex_mem_addr[31:2], 2'b00};
          dbus.dbus_sel   = selBus;
          dbus.dbus_wdata = storeData;
          stallreq        = 1'b1;
          mem_wreg        = 1'b0;
          if (dbus.dbus_ack) begin
            rdata_d = dbus.dbus_rdata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (isLoad) mem_wdata = loadData;
      end
      default: state_d = IDLE;
    endcase
    if (isMem && misaligned) begin
      addr_err = 1'b1;
      mem_wreg = 1'b0;
    end
    if (isStore) mem_wreg = 1'b0;
    if (rst) begin
      mem_wd          = 5'h0;
      mem_wreg        = 1'b0;
      mem_wdata       = 32'h0;
      mem_hi          = 32'h0;
      mem_lo          = 32'h0;
      mem_whilo       = 1'b0;
      stallreq        = 1'b0;
      addr_err        = 1'b0;
      dbus.dbus_req   = 1'b0;
      dbus.dbus_we    = 1'b0;
      dbus.dbus_addr  = 32'h0;
      dbus.dbus_sel   = 4'b0000;
      dbus.dbus_wdata = 32'h0;
    end
  end

  // State and captured read data; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios followed by randomized ops, with
// expected results computed from a byte-lane arithmetic model of the stage.
module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic        stallreq;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  mem_lsu_if dbusIf ();

  mem_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .ex_whilo    (ex_whilo),
    .ex_aluop    (ex_aluop),
    .ex_mem_addr (ex_mem_addr),
    .ex_reg2     (ex_reg2),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .mem_whilo   (mem_whilo),
    .stallreq    (stallreq),
    .addr_err    (addr_err),
    .dbus        (dbusIf.master)
  );

  // Free-running pipeline clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

  function automatic bit refIsLoad(input logic [7:0] op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction

  function automatic bit refIsStore(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic int refSize(input logic [7:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit refMisaligned(input logic [7:0] op, input logic [31:0] addr);
    return (addr % refSize(op)) != 0;
  endfunction

  function automatic logic [3:0] refSel(input logic [7:0] op, input logic [31:0] addr);
    int a;
    a = addr % 4;
    if (refSize(op) == 1) return 4'(8 >> a);
    if (refSize(op) == 2) return 4'(12 >> a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] refStoreData(input logic [7:0] op, input logic [31:0] r2);
    logic [31:0] b, h;
    b = r2 % 256;
    h = r2 % 65536;
    if (refSize(op) == 1) return b * 32'h0101_0101;
    if (refSize(op) == 2) return h * 32'h0001_0001;
    return r2;
  endfunction

  function automatic logic [31:0] refLoad(input logic [7:0] op, input logic [31:0] addr,
                                          input logic [31:0] word);
    int a, sz, shift;
    logic [31:0] v;
    a  = addr % 4;
    sz = refSize(op);
    if (sz == 4) return word;
    shift = 8 * (4 - sz - a);
    v = (word >> shift) % (32'd1 << (8 * sz));
    if ((op == LB || op == LH) && v >= (32'd1 << (8 * sz - 1)))
      v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] r2);
    ex_aluop    = op;
    ex_mem_addr = addr;
    ex_reg2     = r2;
    ex_wd       = 5'($urandom_range(1, 31));
    ex_wreg     = 1'b1;
    ex_wdata    = $urandom;
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_whilo    = 1'($urandom_range(0, 1));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    dbusIf.dbus_ack   = 1'b0;
    dbusIf.dbus_rdata = $urandom;
  endtask

  task automatic runMemOp(input int nWait, input logic [31:0] word);
    logic [7:0]  op;
    logic [31:0] addr;
    op   = ex_aluop;
    addr = ex_mem_addr;
    for (int k = 0; k <= nWait; k++) begin
      dbusIf.dbus_ack   = (k == nWait);
      dbusIf.dbus_rdata = (k == nWait) ? word : $urandom;
      @(negedge clk);
      checkOutput("req", 32'(dbusIf.dbus_req), 32'd1);
      checkOutput("stall", 32'(stallreq), 32'd1);
      checkOutput("wreg_busy", 32'(mem_wreg), 32'd0);
      checkOutput("we", 32'(dbusIf.dbus_we), 32'(refIsStore(op)));
      checkOutput("addr", dbusIf.dbus_addr, addr - (addr % 4));
      checkOutput("sel", 32'(dbusIf.dbus_sel), 32'(refSel(op, addr)));
      if (refIsStore(op)) checkOutput("wdata_bus", dbusIf.dbus_wdata, refStoreData(op, ex_reg2));
      stepCycle();
    end
    dbusIf.dbus_ack = 1'b1;
    @(negedge clk);
    checkOutput("done_req", 32'(dbusIf.dbus_req), 32'd0);
    checkOutput("done_stall", 32'(stallreq), 32'd0);
    checkOutput("done_wreg", 32'(mem_wreg), refIsLoad(op) ? 32'(ex_wreg) : 32'd0);
    if (refIsLoad(op)) checkOutput("load_data", mem_wdata, refLoad(op, addr, word));
    stepCycle();
  endtask

  task automatic runMisaligned();
    dbusIf.dbus_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("mis_err", 32'(addr_err), 32'd1);
    checkOutput("mis_req", 32'(dbusIf.dbus_req), 32'd0);
    checkOutput("mis_wreg", 32'(mem_wreg), 32'd0);
    checkOutput("mis_stall", 32'(stallreq), 32'd0);
    checkOutput("mis_wdata", mem_wdata, ex_wdata);
    stepCycle();
    checkOutput("mis_one_cycle", 32'(addr_err), 32'd1);
  endtask

  task automatic runPassThrough();
    dbusIf.dbus_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("pt_wd", 32'(mem_wd), 32'(ex_wd));
    checkOutput("pt_wreg", 32'(mem_wreg), 32'(ex_wreg));
    checkOutput("pt_wdata", mem_wdata, ex_wdata);
    checkOutput("pt_hi", mem_hi, ex_hi);
    checkOutput("pt_lo", mem_lo, ex_lo);
    checkOutput("pt_whilo", 32'(mem_whilo), 32'(ex_whilo));
    checkOutput("pt_stall", 32'(stallreq), 32'd0);
    checkOutput("pt_req", 32'(dbusIf.dbus_req), 32'd0);
    checkOutput("pt_err", 32'(addr_err), 32'd0);
    stepCycle();
  endtask

  // Directed scenarios, then randomized ops checked against the lane model.
  initial begin
    logic [7:0] opList [8];
    logic [7:0] op;
    logic [31:0] addr;
    opList = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

    rst = 1'b1;
    dbusIf.dbus_ack   = 1'b0;
    dbusIf.dbus_rdata = 32'h0;
    applyStimulus(LW, 32'h0000_4000, 32'h1111_2222);
    @(negedge clk);
    checkOutput("rst_req", 32'(dbusIf.dbus_req), 32'd0);
    checkOutput("rst_stall", 32'(stallreq), 32'd0);
    checkOutput("rst_wd", 32'(mem_wd), 32'd0);
    checkOutput("rst_wreg", 32'(mem_wreg), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_hi", mem_hi, 32'd0);
    checkOutput("rst_addr", dbusIf.dbus_addr, 32'd0);
    checkOutput("rst_err", 32'(addr_err), 32'd0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    runMemOp(1, 32'hCAFE_BABE);

    applyStimulus(8'h21, 32'h0, 32'h0);
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234; ex_whilo = 1'b1;
    runPassThrough();

    applyStimulus(LB, 32'h0000_1001, 32'h0);
    runMemOp(0, 32'h00F0_0000);
    applyStimulus(LBU, 32'h0000_1001, 32'h0);
    runMemOp(0, 32'h00F0_0000);

    applyStimulus(SH, 32'h0000_2002, 32'hABCD_1234);
    runMemOp(3, 32'h0);

    applyStimulus(LW, 32'h0000_3002, 32'h0);
    runMisaligned();

    applyStimulus(LW, 32'h0000_5000, 32'h0);
    dbusIf.dbus_ack = 1'b0;
    @(negedge clk);
    checkOutput("wait_req0", 32'(dbusIf.dbus_req), 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("wait_req1", 32'(dbusIf.dbus_req), 32'd1);
    checkOutput("wait_stall1", 32'(stallreq), 32'd1);
    stepCycle();
    rst = 1'b1;
    dbusIf.dbus_ack   = 1'b1;
    dbusIf.dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("abort_req", 32'(dbusIf.dbus_req), 32'd0);
    checkOutput("abort_stall", 32'(stallreq), 32'd0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(LH, 32'h0000_6002, 32'h0);
    runMemOp(2, 32'h1234_8765);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        applyStimulus(8'($urandom_range(0, 8'hDF)), $urandom, $urandom);
        runPassThrough();
      end else begin
        op   = opList[$urandom_range(0, 7)];
        addr = $urandom;
        applyStimulus(op, addr, $urandom);
        if (refMisaligned(op, addr)) runMisaligned();
        else runMemOp($urandom_range(0, 3), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
